sys_control_rx: RTL and testbench



---
 rtl/sys_ctrl_pkg.sv | 23 ++
 rtl/sys_control_rx_if.sv | 32 +++
 rtl/sys_ctrl_frame_timer.sv | 31 +++
 rtl/sys_control_rx.sv | 131 +++++++++++++
 tb/tb_sys_control_rx.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the UART receive-side command decoder.
package sys_ctrl_pkg;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  // RF locations that receive the two ALU operands of a CC frame.
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN
  } rx_state_e;

endpackage

// File: rtl/sys_control_rx_if.sv
// Bus bundle between the UART RX byte source, the command decoder and the RF/ALU.
// Handshake: uart_rx_data_valid_in is a one-cycle pulse qualifying uart_rx_data_in;
// there is no ready/backpressure, so every pulse is consumed in the cycle it appears.
// All RF/ALU strobes and frame_abort_out are one-cycle pulses; addr/data/fun hold between strobes.
interface sys_control_rx_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4,
  parameter int FUN_W = 4
);
  logic [WIDTH-1:0] uart_rx_data_in;
  logic             uart_rx_data_valid_in;
  logic             rf_wr_en_out;
  logic             rf_rd_en_out;
  logic [ADDR-1:0]  rf_addr_out;
  logic [WIDTH-1:0] rf_wr_data_out;
  logic             alu_en_out;
  logic [FUN_W-1:0] alu_fun_out;
  logic             frame_abort_out;
  logic             busy_out;

  modport master (
    output uart_rx_data_in, uart_rx_data_valid_in,
    input  rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out,
    input  alu_en_out, alu_fun_out, frame_abort_out, busy_out
  );

  modport slave (
    input  uart_rx_data_in, uart_rx_data_valid_in,
    output rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out,
    output alu_en_out, alu_fun_out, frame_abort_out, busy_out
  );
endinterface

// File: rtl/sys_ctrl_frame_timer.sv
// Inter-byte idle counter for a frame in progress; flags expiry on the TIMEOUT-th empty cycle.
module sys_ctrl_frame_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic byte_valid_i,
  input  logic active_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts empty non-idle cycles seen so far, so reaching LAST with no
  // byte this cycle means TIMEOUT consecutive empty cycles have elapsed.
  assign expired_o = (TIMEOUT != 0) && active_i && !byte_valid_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if ((TIMEOUT == 0) || !active_i || byte_valid_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sys_control_rx.sv
// Receive-side command decoder: parses framed UART bytes into RF write/read and ALU strobes.
module sys_control_rx
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sys_control_rx_if.slave      bus,
  output rx_state_e            dbg_state_out
);
  rx_state_e        state_q, state_d;
  logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic             rf_rd_en_q, rf_rd_en_d;
  logic [ADDR-1:0]  rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic             alu_en_q, alu_en_d;
  logic [FUN_W-1:0] alu_fun_q, alu_fun_d;
  logic             abort_q, abort_d;
  logic             expired;

  logic [WIDTH-1:0] rx_byte;
  logic             rx_valid;
  assign rx_byte  = bus.uart_rx_data_in;
  assign rx_valid = bus.uart_rx_data_valid_in;

  sys_ctrl_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .byte_valid_i (rx_valid),
    .active_i     (state_q != ST_IDLE),
    .expired_o    (expired)
  );

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    abort_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    // Expiry only fires on a cycle without a byte, so a byte in that cycle wins.
    if (expired) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if      (rx_byte == WIDTH'(RF_WR_CMD))   state_d = ST_WR_ADDR;
          else if (rx_byte == WIDTH'(RF_RD_CMD))   state_d = ST_RD_ADDR;
          else if (rx_byte == WIDTH'(ALU_OP_CMD))  state_d = ST_OP_A;
          else if (rx_byte == WIDTH'(ALU_NOP_CMD)) state_d = ST_ALU_FUN;
        end
        ST_WR_ADDR: begin
          wr_addr_d = rx_byte[ADDR-1:0];
          state_d   = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = wr_addr_q;
          rf_wr_data_d = rx_byte;
          state_d      = ST_IDLE;
        end
        ST_RD_ADDR: begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = rx_byte[ADDR-1:0];
          state_d    = ST_IDLE;
        end
        ST_OP_A: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR'(OPA_ADDR);
          rf_wr_data_d = rx_byte;
          state_d      = ST_OP_B;
        end
        ST_OP_B: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR'(OPB_ADDR);
          rf_wr_data_d = rx_byte;
          state_d      = ST_ALU_FUN;
        end
        ST_ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_byte[FUN_W-1:0];
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      abort_q      <= abort_d;
    end
  end

  assign bus.rf_wr_en_out    = rf_wr_en_q;
  assign bus.rf_rd_en_out    = rf_rd_en_q;
  assign bus.rf_addr_out     = rf_addr_q;
  assign bus.rf_wr_data_out  = rf_wr_data_q;
  assign bus.alu_en_out      = alu_en_q;
  assign bus.alu_fun_out     = alu_fun_q;
  assign bus.frame_abort_out = abort_q;
  assign bus.busy_out        = (state_q != ST_IDLE);
  assign dbg_state_out       = state_q;
endmodule

// File: tb/tb_sys_control_rx.sv
// Directed bench for the UART command decoder, using a short frame timeout.
module tb_sys_control_rx;
  import sys_ctrl_pkg::*;

  localparam int TO = 8;

  logic      clk;
  logic      reset_n;
  rx_state_e dbg_state;
  int        checks;
  int        errors;

  sys_control_rx_if #(.WIDTH(8), .ADDR(4), .FUN_W(4)) bus ();

  sys_control_rx #(.WIDTH(8), .ADDR(4), .FUN_W(4), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .dbg_state_out (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_data_valid_in = v;
    bus.uart_rx_data_in       = b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic wr, input logic rd,
                            input logic alu, input logic ab, input logic [3:0] addr,
                            input logic [7:0] wdata, input logic [3:0] fun, input logic busy);
    chk({tag, ".rf_wr_en"},   32'(bus.rf_wr_en_out),    32'(wr));
    chk({tag, ".rf_rd_en"},   32'(bus.rf_rd_en_out),    32'(rd));
    chk({tag, ".alu_en"},     32'(bus.alu_en_out),      32'(alu));
    chk({tag, ".abort"},      32'(bus.frame_abort_out), 32'(ab));
    chk({tag, ".rf_addr"},    32'(bus.rf_addr_out),     32'(addr));
    chk({tag, ".rf_wr_data"}, 32'(bus.rf_wr_data_out),  32'(wdata));
    chk({tag, ".alu_fun"},    32'(bus.alu_fun_out),     32'(fun));
    chk({tag, ".busy"},       32'(bus.busy_out),        32'(busy));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.uart_rx_data_valid_in = 1'b0;
    bus.uart_rx_data_in       = 8'h00;
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // RF write AA,05,3C
    cycle(1, 8'hAA);
    expect_out("wr.op", 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    cycle(1, 8'h05);
    chk("wr.busy_after_op", 32'(bus.busy_out), 32'd1);
    cycle(1, 8'h3C);
    cycle(0, 8'h00);
    expect_out("wr.strobe", 1, 0, 0, 0, 4'h5, 8'h3C, 4'h0, 0);
    cycle(0, 8'h00);
    expect_out("wr.after", 0, 0, 0, 0, 4'h5, 8'h3C, 4'h0, 0);

    // RF read BB,0A then unknown 77
    cycle(1, 8'hBB);
    cycle(1, 8'h0A);
    cycle(0, 8'h00);
    expect_out("rd.strobe", 0, 1, 0, 0, 4'hA, 8'h3C, 4'h0, 0);
    cycle(1, 8'h77);
    cycle(0, 8'h00);
    expect_out("unk.1", 0, 0, 0, 0, 4'hA, 8'h3C, 4'h0, 0);
    cycle(0, 8'h00);
    expect_out("unk.2", 0, 0, 0, 0, 4'hA, 8'h3C, 4'h0, 0);

    // ALU frame CC,12,34,03 back-to-back, then DD,F8
    cycle(1, 8'hCC);
    cycle(1, 8'h12);
    cycle(1, 8'h34);
    expect_out("alu.opa", 1, 0, 0, 0, 4'h0, 8'h12, 4'h0, 1);
    cycle(1, 8'h03);
    expect_out("alu.opb", 1, 0, 0, 0, 4'h1, 8'h34, 4'h0, 1);
    cycle(0, 8'h00);
    expect_out("alu.exec", 0, 0, 1, 0, 4'h1, 8'h34, 4'h3, 0);
    cycle(1, 8'hDD);
    cycle(1, 8'hF8);
    expect_out("nop.mid", 0, 0, 0, 0, 4'h1, 8'h34, 4'h3, 1);
    cycle(0, 8'h00);
    expect_out("nop.exec", 0, 0, 1, 0, 4'h1, 8'h34, 4'h8, 0);

    // Timeout: AA,02 then TO empty cycles
    cycle(1, 8'hAA);
    cycle(1, 8'h02);
    for (int i = 1; i <= TO; i++) begin
      cycle(0, 8'h00);
      expect_out($sformatf("to.wait%0d", i), 0, 0, 0, 0, 4'h1, 8'h34, 4'h8, 1);
    end
    cycle(0, 8'h00);
    expect_out("to.abort", 0, 0, 0, 1, 4'h1, 8'h34, 4'h8, 0);
    cycle(0, 8'h00);
    expect_out("to.after", 0, 0, 0, 0, 4'h1, 8'h34, 4'h8, 0);
    cycle(1, 8'hBB);
    cycle(1, 8'h01);
    cycle(0, 8'h00);
    expect_out("to.rd", 0, 1, 0, 0, 4'h1, 8'h34, 4'h8, 0);

    // Byte lands exactly in the expiry cycle
    cycle(1, 8'hAA);
    cycle(1, 8'h02);
    for (int i = 1; i < TO; i++) cycle(0, 8'h00);
    chk("edge.busy", 32'(bus.busy_out), 32'd1);
    cycle(1, 8'h5A);
    cycle(0, 8'h00);
    expect_out("edge.wr", 1, 0, 0, 0, 4'h2, 8'h5A, 4'h8, 0);
    cycle(0, 8'h00);
    expect_out("edge.after", 0, 0, 0, 0, 4'h2, 8'h5A, 4'h8, 0);

    // Reset mid-frame: CC,11 then reset
    cycle(1, 8'hCC);
    cycle(1, 8'h11);
    cycle(0, 8'h00);
    expect_out("rst.opa", 1, 0, 0, 0, 4'h0, 8'h11, 4'h8, 1);
    #2 reset_n = 1'b0;
    #1 expect_out("rst.held", 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
    chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 8'hDD);
    cycle(1, 8'h02);
    cycle(0, 8'h00);
    expect_out("rst.nop", 0, 0, 1, 0, 4'h0, 8'h00, 4'h2, 0);
    cycle(0, 8'h00);
    expect_out("rst.after", 0, 0, 0, 0, 4'h0, 8'h00, 4'h2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
